// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// The rx line is synchronised through two flops and each bit is voted from three samples.
// A one-entry output buffer holds each word until the consumer takes it.
// A completed word that arrives while the buffer is still full is dropped and raises a sticky overrun flag.
module uart_rx_param #(
  parameter int DATA_BITS   = 7,
  parameter int OVERSAMPLE  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rx,
  input  logic                 ready_in,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic [2:0]           state_out,
  output logic                 busy
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_LO  = CW'(H - 1);
  localparam logic [CW-1:0] C_MID = CW'(H);
  localparam logic [CW-1:0] C_HI  = CW'(H + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_armed;
  logic                 r_smp0;
  logic                 r_smp1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_pend;
  logic                 r_frm_pend;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_overrun;

  logic w_maj;
  logic w_last_stop;
  logic w_word_done;
  logic w_frm_final;
  logic w_par_exp;
  logic w_xfer;

  // The bit is voted from the two stored samples plus the live sample at the third point.
  assign w_maj       = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
  assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));
  // The word completes mid-way through the final stop bit, so the receiver resyncs early.
  assign w_word_done = ena && (r_state == S_STOP) && (r_cnt == C_HI) && w_last_stop;
  assign w_frm_final = r_frm_pend | ~w_maj;
  // Expected parity bit: even parity gives XOR of the data; odd parity inverts it.
  assign w_par_exp   = (^r_shift) ^ (PARITY_MODE == 2);
  assign w_xfer      = r_valid & ready_in;

  assign data_out    = r_data_out;
  assign valid_out   = r_valid;
  assign parity_err  = r_par_err;
  assign frame_err   = r_frm_err;
  assign overrun_err = r_overrun;
  assign state_out   = r_state;
  assign busy        = (r_state != S_IDLE);

  // Two-flop synchroniser for the asynchronous rx line. It runs on every clock, whether or not ena is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver FSM. It advances only on oversample ticks and captures the first two vote samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_armed    <= 1'b0;
      r_smp0     <= 1'b0;
      r_smp1     <= 1'b0;
      r_shift    <= '0;
      r_par_pend <= 1'b0;
      r_frm_pend <= 1'b0;
    end else if (ena) begin
      if (r_cnt == C_LO) r_smp0 <= r_rx_s;
      if (r_cnt == C_MID) r_smp1 <= r_rx_s;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // A start needs the line to have been seen high first, so a held-low line never retriggers.
          if (r_armed && !r_rx_s) begin
            r_state    <= S_START;
            r_cnt      <= CW'(1);
            r_armed    <= 1'b0;
            r_par_pend <= 1'b0;
            r_frm_pend <= 1'b0;
          end else if (r_rx_s) begin
            r_armed <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == C_HI && w_maj) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_END) begin
            r_state   <= S_DATA;
            r_cnt     <= '0;
            r_bit_idx <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_HI) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (r_cnt == C_END) begin
            r_cnt <= '0;
            if (r_bit_idx == 4'(DATA_BITS - 1)) begin
              r_state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              r_stop_idx <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_cnt == C_HI) r_par_pend <= w_maj ^ w_par_exp;
          if (r_cnt == C_END) begin
            r_state    <= S_STOP;
            r_cnt      <= '0;
            r_stop_idx <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_HI && w_last_stop) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            if (r_cnt == C_HI) r_frm_pend <= r_frm_pend | ~w_maj;
            if (r_cnt == C_END) begin
              r_cnt      <= '0;
              r_stop_idx <= r_stop_idx + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // One-entry output buffer with a valid/ready handshake and a sticky overrun flag.
  // The handshake runs on every clock, whether or not ena is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (err_clr) r_overrun <= 1'b0;
      if (w_word_done) begin
        if (!r_valid || w_xfer) begin
          r_data_out <= r_shift;
          r_par_err  <= (PARITY_MODE != 0) & r_par_pend;
          r_frm_err  <= w_frm_final;
          r_valid    <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
